// File: rtl/bcd_updown_seg_scan_pkg.sv
// bcd_updown_seg_scan_pkg: glyph constants, digit width and digit-select helper
package bcd_updown_seg_scan_pkg;
    localparam int BCD_W      = 4;
    localparam int MAX_DIGITS = 8;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic logic [MAX_DIGITS-1:0] digit_mask(input logic [2:0] idx);
        return MAX_DIGITS'(1) << idx;
    endfunction
endpackage

// File: rtl/bcd_updown_seg_scan_seg7.sv
// bcd_to_seg7: combinational BCD to active-high abcdefg glyph decoder
module bcd_to_seg7
    import bcd_updown_seg_scan_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [6:0]       seg
);
    // Table lookup; non-BCD codes show a blank digit
    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/bcd_updown_seg_scan.sv
// bcd_updown_seg_scan: prescaled BCD up/down counter with load, wrap pulse and scanned 7-segment drive
module bcd_updown_seg_scan
    import bcd_updown_seg_scan_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int PRESCALE    = 12000000,
    parameter int REFRESH_DIV = 12000,
    parameter bit ACTIVE_LOW  = 1
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    up_dn,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] load_val,
    output logic [BCD_W*DIGITS-1:0] count,
    output logic                    wrap,
    output logic [6:0]              seg,
    output logic [DIGITS-1:0]       an
);
    localparam int CW = BCD_W * DIGITS;
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam int RW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam int SW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    logic [PW-1:0]         presc;
    logic [RW-1:0]         refresh;
    logic [SW-1:0]         scan_idx;
    logic [CW-1:0]         count_nxt;
    logic [CW-1:0]         load_clean;
    logic                  wrap_nxt;
    logic                  chain;
    logic [BCD_W-1:0]      d;
    logic [BCD_W-1:0]      cur_digit;
    logic [6:0]            glyph;
    logic [MAX_DIGITS-1:0] mask;
    logic                  step;
    logic                  refresh_tc;

    assign step       = en && (presc == PW'(PRESCALE - 1));
    assign refresh_tc = refresh == RW'(REFRESH_DIV - 1);
    assign cur_digit  = count[scan_idx * BCD_W +: BCD_W];
    assign mask       = digit_mask(3'(scan_idx));

    // Ripple a step through the digits; a carry/borrow out of the top digit is a wrap.
    // Non-BCD load nibbles are forced to 0 so the count never holds an illegal code.
    always_comb begin
        count_nxt  = count;
        load_clean = '0;
        chain      = 1'b1;
        d          = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d = count[i*BCD_W +: BCD_W];
            if (chain)
                count_nxt[i*BCD_W +: BCD_W] = up_dn ? (d == 4'd9 ? 4'd0 : d + 4'd1)
                                                    : (d == 4'd0 ? 4'd9 : d - 4'd1);
            chain = chain && (up_dn ? d == 4'd9 : d == 4'd0);
            load_clean[i*BCD_W +: BCD_W] = load_val[i*BCD_W +: BCD_W] > 4'd9 ? 4'd0
                                                                            : load_val[i*BCD_W +: BCD_W];
        end
        wrap_nxt = chain;
    end

    // Count register: load beats enable, wrap pulses only on a real step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            presc <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                count <= load_clean;
                presc <= '0;
            end else if (en) begin
                presc <= step ? '0 : presc + 1'b1;
                if (step) begin
                    count <= count_nxt;
                    wrap  <= wrap_nxt;
                end
            end
        end
    end

    // Free-running refresh timer advancing the selected digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh  <= '0;
            scan_idx <= '0;
        end else begin
            refresh <= refresh_tc ? '0 : refresh + 1'b1;
            if (refresh_tc)
                scan_idx <= (DIGITS == 1 || scan_idx == SW'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
        end
    end

    bcd_to_seg7 u_seg7 (
        .bcd (cur_digit),
        .seg (glyph)
    );

    // Display registers; board polarity is applied only here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= ACTIVE_LOW ? ~SEG_0 : SEG_0;
            an  <= ACTIVE_LOW ? ~DIGITS'(1) : DIGITS'(1);
        end else begin
            seg <= ACTIVE_LOW ? ~glyph : glyph;
            an  <= ACTIVE_LOW ? ~mask[DIGITS-1:0] : mask[DIGITS-1:0];
        end
    end
endmodule
